// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch front end: FSM states and buffer entry.
package fetch_pkg;
`include "constants.svh"

    localparam int FETCH_AWIDTH = 32;
    localparam int FETCH_DWIDTH = 32;
    localparam int PC_STEP      = 4;

    typedef enum logic [1:0] {BOOT, RUN, FLUSH, HALT} fetch_state_e;

    typedef struct packed {
        logic [FETCH_AWIDTH-1:0] pc;
        logic [FETCH_DWIDTH-1:0] insn;
    } fetch_entry_t;
endpackage

// File: rtl/constants.svh
// Project-wide shared constants, included into package scope.
`ifndef CONSTANTS_SVH
`define CONSTANTS_SVH
localparam logic [31:0] ZERO = 32'h0;
`endif

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with occupancy count and synchronous clear; no write-to-read bypass.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clr_i,
    input  logic                   push_i,
    input  logic [W-1:0]           wdata_i,
    input  logic                   pop_i,
    output logic [W-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push, do_pop;

    assign empty_o = (cnt == '0);
    assign do_push = push_i && (cnt != (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem[rd_ptr];
    assign count_o = cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= W'(ZERO);
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clr_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata_i;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end with redirect flush and stale-response dropping.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect target halts fetch (sticky misaligned_o).
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                AWIDTH   = FETCH_AWIDTH,
    parameter int                DWIDTH   = FETCH_DWIDTH,
    parameter logic [AWIDTH-1:0] RESET_PC = 32'h0100_0000,
    parameter int                DEPTH    = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              redirect_valid_i,
    input  logic [AWIDTH-1:0] redirect_pc_i,
    output logic              imem_req_valid_o,
    input  logic              imem_req_ready_i,
    output logic [AWIDTH-1:0] imem_req_addr_o,
    input  logic              imem_rsp_valid_i,
    input  logic [DWIDTH-1:0] imem_rsp_data_i,
    output logic              insn_valid_o,
    input  logic              insn_ready_i,
    output logic [DWIDTH-1:0] insn_o,
    output logic [AWIDTH-1:0] insn_pc_o
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic              misaligned_o
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e      state_q, state_d;
    logic [AWIDTH-1:0] pc_q, redirect_tgt, tag_head;
    logic [CW-1:0]     drop_q, drop_d, outstanding, buf_count;
    logic [CW:0]       occupancy;
    logic              tag_empty, buf_empty, req_fire, rsp_hit, buf_push, buf_pop, trap;
    fetch_entry_t      buf_wdata, buf_head;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign trap         = redirect_valid_i && (redirect_pc_i[1:0] != ZERO[1:0]);
    assign redirect_tgt = redirect_pc_i;
`else
    assign trap         = 1'b0;
    assign redirect_tgt = redirect_pc_i & ~AWIDTH'(PC_STEP - 1);
`endif

    // Reserve buffer space for every in-flight response so responses never stall.
    assign occupancy        = {1'b0, outstanding} + {1'b0, buf_count};
    assign imem_req_valid_o = (state_q == RUN || state_q == FLUSH) && !redirect_valid_i
                              && (occupancy < (CW+1)'(DEPTH));
    assign imem_req_addr_o  = pc_q;
    assign req_fire         = imem_req_valid_o && imem_req_ready_i;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_hit          = imem_rsp_valid_i && !tag_empty;
    assign buf_push         = rsp_hit && !redirect_valid_i && (drop_q == '0);
    assign insn_valid_o     = !buf_empty && !redirect_valid_i;
    assign buf_pop          = insn_valid_o && insn_ready_i;
    assign insn_o           = buf_head.insn;
    assign insn_pc_o        = buf_head.pc;
    assign buf_wdata        = '{pc: tag_head, insn: imem_rsp_data_i};

    always_comb begin
        drop_d = drop_q;
        if (redirect_valid_i)            drop_d = outstanding - CW'(rsp_hit);
        else if (rsp_hit && drop_q != '0) drop_d = drop_q - 1'b1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:       state_d = trap ? HALT : RUN;
            RUN, FLUSH: state_d = trap ? HALT : ((drop_d != '0) ? FLUSH : RUN);
            HALT:       state_d = HALT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            if (redirect_valid_i) pc_q <= redirect_tgt;
            else if (req_fire)    pc_q <= pc_q + AWIDTH'(PC_STEP);
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)   misaligned_o <= 1'b0;
        else if (trap) misaligned_o <= 1'b1;
    end
`endif

    // Tag queue tracks exactly the responses still owed, stale or not.
    fetch_fifo #(.W(AWIDTH), .DEPTH(DEPTH)) u_tag_q (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (1'b0),
        .push_i  (req_fire),
        .wdata_i (pc_q),
        .pop_i   (rsp_hit),
        .rdata_o (tag_head),
        .count_o (outstanding),
        .empty_o (tag_empty)
    );

    fetch_fifo #(.W($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_insn_buf (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (redirect_valid_i),
        .push_i  (buf_push),
        .wdata_i (buf_wdata),
        .pop_i   (buf_pop),
        .rdata_o (buf_head),
        .count_o (buf_count),
        .empty_o (buf_empty)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: memory model returns data = address.
module tb_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0100_0000;

    logic        clk = 1'b0, rst_ni = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        req_valid, req_ready = 1'b0;
    logic [31:0] req_addr;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;
    logic        insn_valid, insn_ready = 1'b1;
    logic [31:0] insn, insn_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misaligned;
`endif

    fetch_unit #(.AWIDTH(32), .DWIDTH(32), .RESET_PC(RST_PC), .DEPTH(2)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .imem_req_valid_o (req_valid),
        .imem_req_ready_i (req_ready),
        .imem_req_addr_o  (req_addr),
        .imem_rsp_valid_i (rsp_valid),
        .imem_rsp_data_i  (rsp_data),
        .insn_valid_o     (insn_valid),
        .insn_ready_i     (insn_ready),
        .insn_o           (insn),
        .insn_pc_o        (insn_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misaligned_o     (misaligned)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_t;

    mem_t        rq[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_pc[$];
    int          checks = 0, failures = 0;
    int          cyc = 0, lat = 1, budget = 0, accepts = 0;
    logic [31:0] next_pc = RST_PC;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: grants only budgeted requests, answers after lat cycles.
    initial begin : mem_model
        forever begin
            @(negedge clk); #1;
            cyc++;
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                rsp_valid = 1'b1;
                rsp_data  = rq[0].addr;
                void'(rq.pop_front());
            end else begin
                rsp_valid = 1'b0;
                rsp_data  = '0;
            end
            req_ready = (budget > 0);
            if (rst_ni && req_valid && req_ready) begin
                if (exp_addr.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL req_unexpected: got addr %h with no request expected", req_addr);
                end else begin
                    check("req_addr", req_addr, exp_addr.pop_front());
                end
                rq.push_back('{addr: req_addr, due: cyc + lat});
                budget--;
                accepts++;
            end
        end
    end

    // Monitor: compares every handed-over instruction against the scoreboard.
    initial begin : monitor
        logic [31:0] e;
        forever begin
            @(negedge clk); #2;
            if (rst_ni && insn_valid && insn_ready) begin
                if (exp_pc.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL insn_unexpected: got pc %h with none expected", insn_pc);
                end else begin
                    e = exp_pc.pop_front();
                    check("insn_pc", insn_pc, e);
                    check("insn_data", insn, e);
                end
            end
        end
    end

    task automatic fetch_n(input int n);
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(next_pc);
            exp_pc.push_back(next_pc);
            next_pc += 32'd4;
        end
        budget += n;
    endtask

    task automatic stale(input int n);
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(next_pc);
            next_pc += 32'd4;
        end
        budget += n;
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((exp_pc.size() != 0 || exp_addr.size() != 0) && k < 300) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k >= 300) begin
            failures++;
            $display("FAIL %s_timeout: %0d insns and %0d requests still pending, required 0",
                     name, exp_pc.size(), exp_addr.size());
        end
        #2;
    endtask

    task automatic wait_inflight(input int n);
        int k = 0;
        do begin
            @(negedge clk); #2;
            k++;
        end while (rq.size() < n && k < 50);
        check("inflight_reached", rq.size(), n);
    endtask

    task automatic release_and_boot(input string name);
        @(negedge clk);
        rst_ni = 1'b1;
        #2 check({name, "_boot_no_req"}, req_valid, 1'b0);
        @(negedge clk); #2;
        check({name, "_first_req_valid"}, req_valid, 1'b1);
        check({name, "_first_req_addr"}, req_addr, RST_PC);
    endtask

    initial begin : stim
        int base, bad;

        // Reset state
        repeat (3) @(negedge clk);
        #2;
        check("rst_req_valid", req_valid, 1'b0);
        check("rst_insn_valid", insn_valid, 1'b0);
        check("rst_req_addr", req_addr, RST_PC);
        check("rst_insn", insn, 32'h0);
        check("rst_insn_pc", insn_pc, 32'h0);

        // Streaming from reset, latency 1
        next_pc = RST_PC;
        fetch_n(8);
        release_and_boot("boot");
        drain("stream");

        // Decode backpressure: only DEPTH words may be fetched ahead
        @(negedge clk);
        insn_ready = 1'b0;
        base = accepts;
        fetch_n(8);
        repeat (10) @(negedge clk);
        #2;
        check("bp_accepts", accepts - base, 2);
        check("bp_insn_valid", insn_valid, 1'b1);
        check("bp_head_pc", insn_pc, exp_pc[0]);
        @(negedge clk);
        insn_ready = 1'b1;
        drain("backpressure");

        // Redirect with two requests in flight, latency 3
        lat = 3;
        stale(2);
        wait_inflight(2);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0100_0040;
        #2;
        check("redir_req_valid", req_valid, 1'b0);
        check("redir_insn_valid", insn_valid, 1'b0);
        @(negedge clk);
        redirect_valid = 1'b0;
        next_pc = 32'h0100_0040;
        fetch_n(4);
        drain("redirect");

        // Redirect coinciding with a response, then a second redirect
        lat = 2;
        stale(2);
        wait_inflight(2);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0100_0060;
        #2 check("redir2a_req_valid", req_valid, 1'b0);
        @(negedge clk);
        redirect_pc = 32'h0100_0080;
        #2 check("redir2b_req_valid", req_valid, 1'b0);
        @(negedge clk);
        redirect_valid = 1'b0;
        next_pc = 32'h0100_0080;
        fetch_n(4);
        drain("double_redirect");

        // Unsolicited response while idle must be ignored
        rq.push_back('{addr: 32'hDEAD_BEEF, due: cyc + 2});
        repeat (5) @(negedge clk);
        fetch_n(2);
        drain("protocol_error");

        // Asynchronous reset with two outstanding
        lat = 3;
        stale(2);
        wait_inflight(2);
        @(negedge clk);
        #3 rst_ni = 1'b0;
        #1;
        check("midrst_req_valid", req_valid, 1'b0);
        check("midrst_insn_valid", insn_valid, 1'b0);
        check("midrst_req_addr", req_addr, RST_PC);
        check("midrst_insn_pc", insn_pc, 32'h0);
        rq.delete();
        exp_addr.delete();
        budget = 0;
        repeat (3) @(negedge clk);
        lat = 1;
        next_pc = RST_PC;
        fetch_n(4);
        release_and_boot("midrst");
        drain("after_reset");

`ifdef FETCH_MISALIGN_TRAP_EN
        // Misaligned redirect halts fetch until reset
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0100_0042;
        @(negedge clk);
        redirect_valid = 1'b0;
        #2;
        check("trap_misaligned", misaligned, 1'b1);
        check("trap_req_valid", req_valid, 1'b0);
        budget = 4;
        bad = 0;
        repeat (10) begin
            @(negedge clk); #2;
            if (req_valid) bad++;
        end
        check("halt_no_req", bad, 0);
        budget = 0;
        @(negedge clk);
        rst_ni = 1'b0;
        #1 check("trap_rst_clears", misaligned, 1'b0);
        repeat (2) @(negedge clk);
        next_pc = RST_PC;
        fetch_n(2);
        release_and_boot("trap");
        drain("after_trap");
`else
        // Low target bits are ignored on redirect
        bad = 0;
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0100_0042;
        @(negedge clk);
        redirect_valid = 1'b0;
        next_pc = 32'h0100_0040;
        fetch_n(2);
        drain("align_force");
        check("align_no_extra", bad, 0);
`endif

        repeat (4) @(negedge clk);
        check("final_no_pending", exp_pc.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
